// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: diff = x - y, borrow set when y exceeds x.
module half_subtractor (
    output logic diff,
    output logic borrow,
    input  logic x,
    input  logic y
);

    assign diff   = x ^ y;
    assign borrow = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor computing a - b over WIDTH clocks with a stored borrow.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
//
// state    | meaning
// ST_IDLE  | waiting for start; results from the last operation held
// ST_SHIFT | one difference bit produced per clock, LSB first
// ST_DONE  | done pulse cycle, then back to ST_IDLE
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [CNT_W-1:0] cnt;
    logic             borrow_q;

    logic hs0_diff, hs0_borrow;
    logic d_bit, hs1_borrow;
    logic borrow_nxt;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;
`endif

    // Full subtractor built from two half subtractors: (a0 - b0) - borrow_in.
    half_subtractor u_hs0 (
        .diff   (hs0_diff),
        .borrow (hs0_borrow),
        .x      (a_sr[0]),
        .y      (b_sr[0])
    );

    half_subtractor u_hs1 (
        .diff   (d_bit),
        .borrow (hs1_borrow),
        .x      (hs0_diff),
        .y      (borrow_q)
    );

    assign borrow_nxt = hs0_borrow | hs1_borrow;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            borrow_q   <= 1'b0;
            cnt        <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
`ifdef SERIAL_SUB_OVF_EN
            overflow   <= 1'b0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr       <= a;
                        b_sr       <= b;
                        borrow_q   <= 1'b0;
                        cnt        <= '0;
                        diff       <= '0;
                        borrow_out <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        overflow   <= 1'b0;
                        a_msb      <= a[WIDTH-1];
                        b_msb      <= b[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    diff     <= {d_bit, diff[WIDTH-1:1]};
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    borrow_q <= borrow_nxt;
                    cnt      <= cnt + CNT_W'(1);
                    // Last bit: results are registered now so they are valid alongside done.
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        borrow_out <= borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        overflow   <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8); overflow checks need SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         overflow;
`endif

    int compared;
    int mismatched;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full operation from IDLE: accept, watch busy/done timing, check results and hold.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic [W-1:0] exp_diff, input logic exp_borrow,
                          input logic exp_ovf);
        a = ta;
        b = tb_;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        tick(W - 1);
        check({tag, " no_done_early"}, 32'(done), 32'd0);
        tick(1);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_low"}, 32'(busy), 32'd0);
        check({tag, " diff"}, 32'(diff), 32'(exp_diff));
        check({tag, " borrow_out"}, 32'(borrow_out), 32'(exp_borrow));
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bz) $display("unreachable");
`endif
        tick(1);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " diff_hold"}, 32'(diff), 32'(exp_diff));
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick(2);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset borrow_out", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset overflow", 32'(overflow), 32'd0);
`endif
        rst = 1'b0;
        tick(1);

        run_op("05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        run_op("03-05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        run_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op("7F-FF", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);

        // start during SHIFT is ignored; held start is accepted on return to IDLE
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        tick(W - 3);
        check("ignore done", 32'(done), 32'd1);
        check("ignore diff", 32'(diff), 32'h0F);
        check("ignore borrow_out", 32'(borrow_out), 32'd0);
        tick(1);
        check("ignore done_drop", 32'(done), 32'd0);
        check("ignore not_restarted", 32'(busy), 32'd0);
        tick(1);
        check("second accept busy", 32'(busy), 32'd1);
        start = 1'b0;
        tick(W);
        check("second done", 32'(done), 32'd1);
        check("second diff", 32'(diff), 32'h55);
        check("second borrow_out", 32'(borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("second overflow", 32'(overflow), 32'd1);
`endif
        tick(1);

        // reset while shifting aborts with no done pulse
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort diff", 32'(diff), 32'd0);
        check("abort borrow_out", 32'(borrow_out), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick(1);
            check("abort no_done", 32'(done), 32'd0);
        end
        run_op("09-04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
